// File: rtl/flag_writer.sv
// NZCV condition-flag producer with a one-deep shadow for exception entry/return.
// Optional FLAG_FORWARD_EN macro exposes the next Flags value combinationally on FlagsFwd.
module flag_writer #(
  parameter int         WIDTH      = 32,
  parameter logic [3:0] RESET_NZCV = 4'h0
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             Valid,
  input  logic             CondEx,
  input  logic [1:0]       FlagWrite,
  input  logic [WIDTH-1:0] ALUResult,
  input  logic             ALUCarry,
  input  logic             ALUOverflow,
  input  logic             SaveReq,
  input  logic             RestoreReq,
  output logic [3:0]       Flags,
  output logic [3:0]       SavedFlags,
  output logic             ShadowFull,
  output logic             SeqErr,
  output logic [3:0]       FlagsFwd
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SAVED = 1'b1
  } shadow_state_t;

  shadow_state_t state_r;
  shadow_state_t state_next_s;

  logic [3:0] flags_r;
  logic [3:0] saved_flags_r;
  logic       shadow_full_r;
  logic       seq_err_r;

  logic       we_s;
  logic       n_s;
  logic       z_s;
  logic [3:0] write_flags_s;
  logic [3:0] flags_next_s;
  logic [3:0] saved_next_s;
  logic       save_s;
  logic       restore_s;
  logic       seq_err_s;

  assign we_s = Valid & CondEx;
  assign n_s  = ALUResult[WIDTH-1];
  assign z_s  = (ALUResult == {WIDTH{1'b0}});

  // Merge the selected ALU-derived flag pairs over the current flags
  always_comb begin
    write_flags_s = flags_r;
    if (we_s && FlagWrite[1]) begin
      write_flags_s[3:2] = {n_s, z_s};
    end else begin
      write_flags_s[3:2] = flags_r[3:2];
    end
    if (we_s && FlagWrite[0]) begin
      write_flags_s[1:0] = {ALUCarry, ALUOverflow};
    end else begin
      write_flags_s[1:0] = flags_r[1:0];
    end
  end

  // Shadow sequencing: legal save/restore decode, error detection, next state
  always_comb begin
    save_s       = 1'b0;
    restore_s    = 1'b0;
    seq_err_s    = 1'b0;
    state_next_s = state_r;
    if (SaveReq && RestoreReq) begin
      seq_err_s = 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (SaveReq) begin
            save_s       = 1'b1;
            state_next_s = SAVED;
          end else if (RestoreReq) begin
            seq_err_s = 1'b1;
          end else begin
            state_next_s = IDLE;
          end
        end
        SAVED: begin
          if (RestoreReq) begin
            restore_s    = 1'b1;
            state_next_s = IDLE;
          end else if (SaveReq) begin
            // nested save keeps the original shadow copy
            seq_err_s = 1'b1;
          end else begin
            state_next_s = SAVED;
          end
        end
        default: begin
          state_next_s = IDLE;
        end
      endcase
    end
  end

  // A legal restore wins over any flag write in the same cycle
  always_comb begin
    flags_next_s = write_flags_s;
    saved_next_s = saved_flags_r;
    if (restore_s) begin
      flags_next_s = saved_flags_r;
    end else begin
      flags_next_s = write_flags_s;
    end
    if (save_s) begin
      saved_next_s = flags_r;
    end else begin
      saved_next_s = saved_flags_r;
    end
  end

  // Architectural flag, shadow and status registers
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_r       <= IDLE;
      flags_r       <= RESET_NZCV;
      saved_flags_r <= RESET_NZCV;
      shadow_full_r <= 1'b0;
      seq_err_r     <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      flags_r       <= flags_next_s;
      saved_flags_r <= saved_next_s;
      shadow_full_r <= (state_next_s == SAVED);
      seq_err_r     <= seq_err_s;
    end
  end

  assign Flags      = flags_r;
  assign SavedFlags = saved_flags_r;
  assign ShadowFull = shadow_full_r;
  assign SeqErr     = seq_err_r;

`ifdef FLAG_FORWARD_EN
  assign FlagsFwd = flags_next_s;
`else
  assign FlagsFwd = flags_r;
`endif

endmodule

// File: tb/tb_flag_writer.sv
// Directed self-checking bench for flag_writer (WIDTH=32, RESET_NZCV=0).
module tb_flag_writer;

  logic        CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic        Valid = 1'b0;
  logic        CondEx = 1'b0;
  logic [1:0]  FlagWrite = 2'b00;
  logic [31:0] ALUResult = 32'h0;
  logic        ALUCarry = 1'b0;
  logic        ALUOverflow = 1'b0;
  logic        SaveReq = 1'b0;
  logic        RestoreReq = 1'b0;
  logic [3:0]  Flags;
  logic [3:0]  SavedFlags;
  logic        ShadowFull;
  logic        SeqErr;
  logic [3:0]  FlagsFwd;

  int checks = 0;
  int errors = 0;

  flag_writer #(.WIDTH(32), .RESET_NZCV(4'h0)) dut (
    .CLK(CLK), .RESETn(RESETn), .Valid(Valid), .CondEx(CondEx), .FlagWrite(FlagWrite),
    .ALUResult(ALUResult), .ALUCarry(ALUCarry), .ALUOverflow(ALUOverflow),
    .SaveReq(SaveReq), .RestoreReq(RestoreReq), .Flags(Flags), .SavedFlags(SavedFlags),
    .ShadowFull(ShadowFull), .SeqErr(SeqErr), .FlagsFwd(FlagsFwd)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic c, input logic [1:0] fw,
                       input logic [31:0] res, input logic cy, input logic ov,
                       input logic sv, input logic rs);
    Valid = v; CondEx = c; FlagWrite = fw; ALUResult = res;
    ALUCarry = cy; ALUOverflow = ov; SaveReq = sv; RestoreReq = rs;
  endtask

  initial begin
    tick();
    check_val("rst_flags", 32'(Flags), 32'h0);
    check_val("rst_saved", 32'(SavedFlags), 32'h0);
    check_val("rst_full", 32'(ShadowFull), 32'h0);
    check_val("rst_seqerr", 32'(SeqErr), 32'h0);
    RESETn = 1'b1;

    // basic writes
    drive(1'b1, 1'b1, 2'b11, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    check_val("wr_nzcv", 32'(Flags), 32'hB);
    drive(1'b1, 1'b1, 2'b10, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_val("wr_nz_only", 32'(Flags), 32'h7);

    // gated writes
    drive(1'b1, 1'b0, 2'b11, 32'h8000_0001, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_val("condex_gate", 32'(Flags), 32'h7);
    drive(1'b0, 1'b1, 2'b11, 32'h8000_0001, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_val("valid_gate", 32'(Flags), 32'h7);
    drive(1'b1, 1'b1, 2'b01, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_val("wr_cv_only", 32'(Flags), 32'h4);

    // save with concurrent write, then restore beating a write
    drive(1'b1, 1'b1, 2'b11, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    check_val("save_shadow", 32'(SavedFlags), 32'h4);
    check_val("save_write", 32'(Flags), 32'h8);
    check_val("save_full", 32'(ShadowFull), 32'h1);
    check_val("save_noerr", 32'(SeqErr), 32'h0);
    drive(1'b1, 1'b1, 2'b11, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    check_val("restore_flags", 32'(Flags), 32'h4);
    check_val("restore_full", 32'(ShadowFull), 32'h0);
    check_val("restore_noerr", 32'(SeqErr), 32'h0);

    // illegal sequences
    drive(1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check_val("idle_rst_err", 32'(SeqErr), 32'h1);
    check_val("idle_rst_flags", 32'(Flags), 32'h4);
    check_val("idle_rst_full", 32'(ShadowFull), 32'h0);
    drive(1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    check_val("idle_both_err", 32'(SeqErr), 32'h1);
    check_val("idle_both_full", 32'(ShadowFull), 32'h0);
    drive(1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    check_val("err_pulse_end", 32'(SeqErr), 32'h0);
    check_val("save1_full", 32'(ShadowFull), 32'h1);
    check_val("save1_shadow", 32'(SavedFlags), 32'h4);
    drive(1'b1, 1'b1, 2'b11, 32'h1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    check_val("nested_err", 32'(SeqErr), 32'h1);
    check_val("nested_shadow", 32'(SavedFlags), 32'h4);
    check_val("nested_write", 32'(Flags), 32'h2);
    drive(1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    check_val("saved_both_err", 32'(SeqErr), 32'h1);
    check_val("saved_both_full", 32'(ShadowFull), 32'h1);
    check_val("saved_both_flags", 32'(Flags), 32'h2);
    drive(1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check_val("late_restore", 32'(Flags), 32'h4);
    check_val("late_restore_err", 32'(SeqErr), 32'h0);
    check_val("late_restore_full", 32'(ShadowFull), 32'h0);

    // forwarding path
    drive(1'b1, 1'b1, 2'b11, 32'h1, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
`ifdef FLAG_FORWARD_EN
    check_val("fwd_same_cycle", 32'(FlagsFwd), 32'h2);
`else
    check_val("fwd_registered", 32'(FlagsFwd), 32'h4);
`endif
    tick();
    check_val("fwd_flags", 32'(Flags), 32'h2);
`ifndef FLAG_FORWARD_EN
    check_val("fwd_follows", 32'(FlagsFwd), 32'h2);
`endif

    // async reset mid-save
    drive(1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    check_val("pre_rst_full", 32'(ShadowFull), 32'h1);
    check_val("pre_rst_shadow", 32'(SavedFlags), 32'h2);
    #2;
    RESETn = 1'b0;
    #1;
    check_val("async_flags", 32'(Flags), 32'h0);
    check_val("async_saved", 32'(SavedFlags), 32'h0);
    check_val("async_full", 32'(ShadowFull), 32'h0);
    check_val("async_seqerr", 32'(SeqErr), 32'h0);
    drive(1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    RESETn = 1'b1;
    tick();
    check_val("post_rst_flags", 32'(Flags), 32'h0);
    check_val("post_rst_full", 32'(ShadowFull), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
